// File: rtl/dispense_pkg.sv
// dispense_pkg: shared types and defaults for the dispense scheduler.
// Provides the scheduler state type, the requester count and default durations.
package dispense_pkg;
   localparam int NREQ = 4;
   localparam int DUR0_DEF = 88;
   localparam int DUR1_DEF = 80;
   localparam int DUR2_DEF = 56;
   localparam int DUR3_DEF = 32;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
// Ports: pending - candidate requests; last - previous winner;
//        idx - first set bit searching upward from last+1 (wrapping); valid - any pending.
module rr_pick4
   import dispense_pkg::*;
(
   input  logic [NREQ-1:0] pending,
   input  logic [1:0]      last,
   output logic [1:0]      idx,
   output logic            valid
);
   // Walk from farthest to nearest so the nearest candidate after last wins.
   always_comb begin
      idx = '0;
      for (int k = NREQ; k >= 1; k--)
         if (pending[last + 2'(k)]) idx = last + 2'(k);
   end
   assign valid = |pending;
endmodule

// File: rtl/dispense_sched.sv
// dispense_sched: round-robin scheduler for one shared timed output channel.
// Ports: sysclk/rst - clock and async active-high reset; tick - time base pulse;
//        req - request levels (rising edge posts a job); abort - ends running job;
//        out - shared timed output; grant - one-hot owner during RUN; busy - RUN or GAP;
//        done/done_id - completion pulse and owner; pending - latched unserved jobs.
module dispense_sched
   import dispense_pkg::*;
#(
   parameter int CW   = 9,
   parameter int DUR0 = DUR0_DEF,
   parameter int DUR1 = DUR1_DEF,
   parameter int DUR2 = DUR2_DEF,
   parameter int DUR3 = DUR3_DEF,
   parameter int GAP  = 8
)(
   input  logic            sysclk,
   input  logic            rst,
   input  logic            tick,
   input  logic [NREQ-1:0] req,
   input  logic            abort,
   output logic            out,
   output logic [NREQ-1:0] grant,
   output logic            busy,
   output logic            done,
   output logic [1:0]      done_id,
   output logic [NREQ-1:0] pending
);
   if (DUR0 < 1 || DUR1 < 1 || DUR2 < 1 || DUR3 < 1 || GAP < 0 ||
       DUR0 >= 2**CW || DUR1 >= 2**CW || DUR2 >= 2**CW || DUR3 >= 2**CW || GAP >= 2**CW) begin : g_bad_param
      $error("dispense_sched: duration or gap does not fit the counter width");
   end
   localparam logic [CW-1:0] GAP_CNT = CW'(GAP);
   state_t          state;
   logic [CW-1:0]   cnt, dur;
   logic [1:0]      rr_last, w;
   logic [NREQ-1:0] req_q, rise, take;
   logic            valid, start, stop, fin;
   rr_pick4 u_pick (
      .pending(pending),
      .last   (rr_last),
      .idx    (w),
      .valid  (valid)
   );
   assign rise  = req & ~req_q;
   assign start = state == ST_IDLE && valid;
   assign take  = start ? NREQ'(1) << w : '0;
   assign dur   = w == 2'd0 ? CW'(DUR0) : w == 2'd1 ? CW'(DUR1) : w == 2'd2 ? CW'(DUR2) : CW'(DUR3);
   // Abort overrides completion, so a job aborted on its last tick reports no done.
   assign stop  = state == ST_RUN && (abort || (tick && cnt == CW'(1)));
   assign fin   = state == ST_RUN && !abort && tick && cnt == CW'(1);
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rr_last <= 2'd3;
         req_q   <= '0;
         pending <= '0;
         out     <= 1'b0;
         grant   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 2'd0;
      end else begin
         req_q   <= req;
         // A rise in the select cycle re-posts the job being taken.
         pending <= (pending & ~take) | rise;
         done    <= fin;
         if (fin) done_id <= rr_last;
         if (start) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            out     <= 1'b1;
            grant   <= take;
            rr_last <= w;
            cnt     <= dur;
         end else if (stop) begin
            out   <= 1'b0;
            grant <= '0;
            state <= GAP == 0 ? ST_IDLE : ST_GAP;
            busy  <= GAP != 0;
            cnt   <= GAP_CNT;
         end else if (state != ST_IDLE && tick) begin
            cnt <= cnt - CW'(1);
            if (state == ST_GAP && cnt == CW'(1)) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/dispense_sched.md
Name: dispense_sched

Overview:
- Schedules one shared timed output channel among four requesters (selection lines).
- Latches request edges as pending jobs and picks a winner round-robin.
- Drives `out` high for the winner's fixed duration, counted in divided-clock tick pulses, then enforces a guard gap before the next job.
- Sits between the debounced selection inputs and the clockdiv tick, replacing ad-hoc per-output sequencing.

Parameters:
- CW, 9, width of the duration/gap counter in bits.
- DUR0, 88, ticks `out` stays high for requester 0 (must be 1..2^CW-1).
- DUR1, 80, ticks for requester 1.
- DUR2, 56, ticks for requester 2.
- DUR3, 32, ticks for requester 3.
- GAP, 8, ticks `out` is held low after each job (0 = no gap).

Ports:
- sysclk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-sysclk-cycle pulse from clockdiv; time base for durations.
- req  in  4  debounced request levels; a rising edge on bit i posts a job for requester i.
- abort  in  1  level; terminates the running job.
- out  out  1  shared timed output.
- grant  out  4  one-hot owner of the channel during RUN, else 0.
- busy  out  1  high in RUN or GAP.
- done  out  1  one-cycle pulse when a job completes its full duration.
- done_id  out  2  requester index; valid with `done`.
- pending  out  4  currently latched, unserved jobs.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; out=0, grant=0, busy=0, done=0, done_id=0, pending=0.
  - counter=0; rr_last=3, so requester 0 has first priority.
  - req_q=0, so a req held high through reset release posts a job on the first clock.
- Edge detect: `rise = req & ~req_q`; req_q <= req every cycle. Each rise sets the matching pending bit. Repeated rises on an already-pending bit have no extra effect (no counting).
- States: IDLE, RUN, GAP.
- IDLE, when pending != 0:
  - Winner w = first set bit searching from rr_last+1, wrapping modulo 4.
  - Same edge: clear pending[w], rr_last<=w, counter<=DUR[w], grant<=onehot(w), out<=1, state<=RUN.
  - Latency: rise on req at cycle n -> out=1 at cycle n+2 (n+1 registers pending).
- RUN:
  - On tick, counter<=counter-1.
  - When tick is high and counter==1: out<=0, grant<=0, done<=1, done_id<=w. Then state<=GAP with counter<=GAP, or state<=IDLE if GAP==0.
  - Result: `out` spans exactly DUR[w] tick pulses (the first partial tick interval is included).
  - No tick: counter holds.
- GAP: on tick, decrement; when tick is high and counter==1, state<=IDLE. `out` stays 0.
- abort:
  - Sampled high in RUN: out<=0, grant<=0, no done pulse, enter GAP (or IDLE if GAP==0). Abort takes priority over completion in the same cycle.
  - Ignored in IDLE and GAP. Pending jobs are untouched.
- `done` is high for exactly one sysclk cycle; it is 0 all other cycles.
- Simultaneous clear and set of pending[w] in the winner-select cycle: set wins, so the job is re-posted.
- Rises during RUN/GAP are latched and served in round-robin order afterwards.
- Width:
  - Counter is CW bits, unsigned, with no wrap: it is only decremented while ≥1.
  - A DURi or GAP value ≥2^CW fails elaboration (generate-time check).
- `busy` = (state != IDLE), registered alongside the state.

Decomposition:
- Shared package `dispense_pkg`: state enum type (IDLE/RUN/GAP), default duration constants (88/80/56/32), and the request-count constant 4.
- One sub-module, `rr_pick4`: combinational 4-way round-robin picker, inputs pending[3:0] and last[1:0], outputs idx[1:0] and valid.
- Edge detect, counter and FSM stay in `dispense_sched`.

Test Plan:
1. Reset mid-RUN (rst pulsed while out=1, asynchronously between edges) -> out, grant, pending, busy go 0 immediately; no done pulse; with req level still high at release, the job is re-posted and out=1 two cycles after release.
2. tick every 4 cycles; req[0] rise -> out=1 two cycles later, high for exactly 88 ticks; done=1 and done_id=0 for one cycle at the falling edge of out; busy stays 1 for 8 more ticks.
3. req[3] and req[1] rising in the same cycle from reset -> requester 1 is served first (32... no: 80 ticks), then requester 3 (32 ticks), separated by 8 gap ticks.
4. Round-robin fairness: after requester 1 is served, req[0] and req[2] are pending -> requester 2 is served before requester 0.
5. abort asserted at tick 10 of a DUR2 job -> out=0 next cycle, no done pulse, gap runs 8 ticks, then the next pending job starts.
6. GAP=0 build, back-to-back pending jobs 0 and 1 -> out falls for exactly one sysclk cycle (the IDLE select cycle) between the 88-tick and 80-tick pulses.
